// File: rtl/ctrl_ordenamiento_if.sv
// rtl/ctrl_ordenamiento_if.sv - load, start, status and output handshake bundle for ctrl_ordenamiento
interface ctrl_ordenamiento_if #(
    parameter int W = 3
);
    logic         carga_valida;
    logic [W-1:0] carga_dato;
    logic         carga_lista;
    logic         inicio;
    logic         ocupado;
    logic         hecho;
    logic         salida_valida;
    logic [W-1:0] salida_dato;
    logic         salida_lista;
    logic [3:0]   intercambios;

    modport slave (
        input  carga_valida, carga_dato, inicio, salida_lista,
        output carga_lista, ocupado, hecho, salida_valida, salida_dato, intercambios
    );

    modport master (
        output carga_valida, carga_dato, inicio, salida_lista,
        input  carga_lista, ocupado, hecho, salida_valida, salida_dato, intercambios
    );
endinterface

// File: rtl/ctrl_ordenamiento.sv
// rtl/ctrl_ordenamiento.sv - load N words, bubble-sort them one compare per cycle, stream them out ascending
// Define ORDEN_TEMPRANO_EN to end the sort after the first pass that makes no swap.
module ctrl_ordenamiento #(
    parameter int N = 4,
    parameter int W = 3
) (
    input  logic               clk,
    input  logic               rst,
    ctrl_ordenamiento_if.slave bus
);
    typedef enum logic [1:0] {CARGA, ORDENA, SALIDA} estado_t;

    localparam logic [3:0] N_L    = 4'(N);
    localparam logic [2:0] LAST_I = 3'(N - 2);
    localparam logic [2:0] LAST_K = 3'(N - 1);

    estado_t      state_q;
    logic [W-1:0] mem_q [8];
    logic [3:0]   count_q;
    logic [2:0]   i_q, p_q, k_q;
    logic [3:0]   interc_q;
    logic         carga_lista_q, ocupado_q, hecho_q, salida_valida_q;
    logic [W-1:0] salida_dato_q;
`ifdef ORDEN_TEMPRANO_EN
    logic         pass_swap_q;
`endif

    logic [2:0]   i_nx, k_nx;
    logic [W-1:0] a, b;
    logic         do_swap, pass_end, last_cmp;

    always_comb begin
        i_nx     = i_q + 3'd1;
        k_nx     = k_q + 3'd1;
        a        = mem_q[i_q];
        b        = mem_q[i_nx];
        do_swap  = a > b;
        pass_end = (i_q == LAST_I - p_q);
`ifdef ORDEN_TEMPRANO_EN
        last_cmp = pass_end && ((p_q == LAST_I) || !(pass_swap_q || do_swap));
`else
        last_cmp = pass_end && (p_q == LAST_I);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= CARGA;
            count_q         <= 4'd0;
            i_q             <= 3'd0;
            p_q             <= 3'd0;
            k_q             <= 3'd0;
            interc_q        <= 4'd0;
            carga_lista_q   <= 1'b1;
            ocupado_q       <= 1'b0;
            hecho_q         <= 1'b0;
            salida_valida_q <= 1'b0;
            salida_dato_q   <= '0;
`ifdef ORDEN_TEMPRANO_EN
            pass_swap_q     <= 1'b0;
`endif
        end else begin
            hecho_q <= 1'b0;
            case (state_q)
                CARGA: begin
                    // A load beats a simultaneous start, so the start only sees count==N.
                    if (bus.carga_valida && carga_lista_q) begin
                        mem_q[count_q[2:0]] <= bus.carga_dato;
                        count_q             <= count_q + 4'd1;
                        carga_lista_q       <= (count_q + 4'd1) < N_L;
                    end else if (bus.inicio && count_q == N_L) begin
                        state_q   <= ORDENA;
                        i_q       <= 3'd0;
                        p_q       <= 3'd0;
                        interc_q  <= 4'd0;
                        ocupado_q <= 1'b1;
`ifdef ORDEN_TEMPRANO_EN
                        pass_swap_q <= 1'b0;
`endif
                    end
                end
                ORDENA: begin
                    if (do_swap) begin
                        mem_q[i_q]  <= b;
                        mem_q[i_nx] <= a;
                        if (interc_q != 4'hF) interc_q <= interc_q + 4'd1;
                    end
                    if (last_cmp) begin
                        state_q         <= SALIDA;
                        ocupado_q       <= 1'b0;
                        hecho_q         <= 1'b1;
                        salida_valida_q <= 1'b1;
                        k_q             <= 3'd0;
                        // Word 0 may be changing at this very edge.
                        salida_dato_q   <= (i_q == 3'd0 && do_swap) ? b : mem_q[0];
                    end else if (pass_end) begin
                        i_q <= 3'd0;
                        p_q <= p_q + 3'd1;
`ifdef ORDEN_TEMPRANO_EN
                        pass_swap_q <= 1'b0;
`endif
                    end else begin
                        i_q <= i_nx;
`ifdef ORDEN_TEMPRANO_EN
                        pass_swap_q <= pass_swap_q || do_swap;
`endif
                    end
                end
                SALIDA: begin
                    if (bus.salida_lista) begin
                        if (k_q == LAST_K) begin
                            state_q         <= CARGA;
                            count_q         <= 4'd0;
                            carga_lista_q   <= 1'b1;
                            salida_valida_q <= 1'b0;
                            salida_dato_q   <= '0;
                            k_q             <= 3'd0;
                        end else begin
                            k_q           <= k_nx;
                            salida_dato_q <= mem_q[k_nx];
                        end
                    end
                end
                default: state_q <= CARGA;
            endcase
        end
    end

    assign bus.carga_lista   = carga_lista_q;
    assign bus.ocupado       = ocupado_q;
    assign bus.hecho         = hecho_q;
    assign bus.salida_valida = salida_valida_q;
    assign bus.salida_dato   = salida_dato_q;
    assign bus.intercambios  = interc_q;
endmodule
